compare_sequencer: RTL and testbench
====================================

COMPARE_SEQUENCER -- requirements
Module: compare_sequencer

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the operand width in bits (legal range 2..32).
REQ-002 Parameter TIMEOUT, default 15, SHALL set the maximum number of cycles slice_req is held high without slice_ack.
REQ-003 clk  in  1  rising-edge clock for all state.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 start  in  1  request a compare of a and b; sampled only when busy=0.
REQ-006 a, b  in  WIDTH  operands; latched when start is accepted.
REQ-007 busy  out  1  high while a compare is in progress.
REQ-008 done  out  1  one-cycle pulse marking valid results.
REQ-009 less_than, equal_to, greater_than  out  1 each  compare result, one-hot when valid, held until the next accepted start.
REQ-010 error  out  1  set with done when a slice response is invalid or times out.
REQ-011 slice_req  out  1  request to the power-gated bit-slice comparator; low means the slice may be gated off.
REQ-012 slice_a, slice_b  out  1 each  operand bits presented with slice_req.
REQ-013 slice_ack  in  1  slice response valid.
REQ-014 slice_lt, slice_eq, slice_gt  in  1 each  slice result, sampled only when slice_ack=1.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, GAP, and DONE, and SHALL reset to IDLE.
REQ-016 In IDLE or DONE with start=1, the block SHALL latch a and b, set the bit index to WIDTH-1, clear error, and enter REQ.
REQ-017 In REQ, slice_req SHALL be 1, with slice_a and slice_b equal to the latched bits at the current index, held stable until ack.
REQ-018 In REQ with slice_ack=1 and exactly one of slice_lt/eq/gt high, the block SHALL act on the slice result as follows.
  - lt or gt: copy the result to the outputs and go to DONE.
  - eq at index 0: set equal_to=1 and go to DONE.
  - eq at index >0: decrement the index and go to GAP.
REQ-019 Bits SHALL be compared MSB first, with early termination at the first unequal bit.
REQ-020 GAP SHALL last exactly one cycle with slice_req=0, then return to REQ; two requests are never back-to-back.
REQ-021 An ack in REQ whose result is not one-hot (including 000 from a reset slice) SHALL cause error=1, results 000, and a transition to DONE.
REQ-022 A timeout SHALL occur after TIMEOUT consecutive REQ cycles with slice_ack=0, causing error=1, results 000, and DONE on the next cycle.
REQ-023 The timeout counter SHALL clear on every entry to REQ.
REQ-024 slice_ack outside REQ SHALL be ignored.
REQ-025 In DONE, done SHALL be 1 and busy SHALL be 0; DONE lasts one cycle, then goes to IDLE unless a new start is accepted.
REQ-026 busy SHALL be 1 in REQ and GAP and 0 otherwise.
REQ-027 Start while busy=1 SHALL be ignored, with no effect on the latched operands.
REQ-028 With a slice that acks in the first REQ cycle, done SHALL assert exactly 2k cycles after the start edge, where k is the number of bits examined.
REQ-029 The result outputs SHALL clear to 000 on start acceptance and change only on the DONE transition.

Reset
REQ-030 A synchronous reset SHALL force the FSM to IDLE and drive busy, done, error, slice_req, slice_a, slice_b, less_than, equal_to and greater_than to 0 on the next edge.
REQ-031 Reset mid-compare SHALL abort the compare without a done pulse, dropping slice_req within one cycle.
REQ-032 Reset SHALL take priority over start and slice_ack in the same cycle.

Structure
REQ-033 The FSM state encoding and the default TIMEOUT constant SHALL reside in a shared package, cmp_pkg, reused by the other comparator blocks.
REQ-034 The RTL SHALL be a single module with no sub-module.
REQ-035 The bench SHALL provide a behavioural responder, cmp_slice_model, with configurable ack delay, stall, and corrupt-result modes.

Verification
REQ-036 Case V1: WIDTH=8, a=0x5A, b=0x5A, zero-delay slice -> 8 requests, done at start+16, equal_to=1, error=0.
REQ-037 Case V2: a=0x80, b=0x7F -> 1 request, done at start+2, greater_than=1; a=0x3C, b=0x3D -> 8 requests, less_than=1 at start+16.
REQ-038 Case V3: the slice never acks -> slice_req high for 15 cycles, then done with error=1 and results 000.
REQ-039 Case V4: the slice acks with result 000 on the first request -> done with error=1, and no further requests are issued.
REQ-040 Case V5: reset asserted at the 3rd request -> slice_req=0 and busy=0 next cycle, no done; a following start=1 with a=1, b=0 -> greater_than=1.
REQ-041 Case V6: start pulses while busy, plus start in the DONE cycle -> the busy pulses are ignored; the DONE-cycle start is accepted and REQ follows the next edge.

Source files
------------

// File: rtl/cmp_pkg.sv
// Shared comparator definitions: sequencer state encoding, result bundle and
// default slice timeout used across the comparator family.
package cmp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } cmp_state_e;

  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_result_t;

  localparam int CMP_TIMEOUT_DEFAULT = 15;

  // A slice answer is only meaningful when exactly one flag is raised.
  function automatic logic is_one_hot3(input cmp_result_t r);
    return (r == 3'b100) || (r == 3'b010) || (r == 3'b001);
  endfunction

endpackage

// File: rtl/compare_sequencer.sv
// Bit-serial magnitude comparator that walks the operands MSB first through a
// power-gated one-bit slice, stopping at the first unequal bit.
module compare_sequencer
  import cmp_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = CMP_TIMEOUT_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             less_than,
  output logic             equal_to,
  output logic             greater_than,
  output logic             error,
  output logic             slice_req,
  output logic             slice_a,
  output logic             slice_b,
  input  logic             slice_ack,
  input  logic             slice_lt,
  input  logic             slice_eq,
  input  logic             slice_gt
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] MSB_IDX  = IW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  cmp_state_e        state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              err_q, err_d;
  cmp_result_t       res_q, res_d;
  cmp_result_t       slice_res;

  assign slice_res = {slice_lt, slice_eq, slice_gt};

  always_comb begin
    // NOTE: every *_d starts from its held value so no path can infer a latch.
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    res_d   = res_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          idx_d   = MSB_IDX;
          cnt_d   = '0;
          err_d   = 1'b0;
          res_d   = '0;
          state_d = ST_REQ;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_REQ: begin
        if (slice_ack) begin
          if (!is_one_hot3(slice_res)) begin
            err_d   = 1'b1;
            res_d   = '0;
            state_d = ST_DONE;
          end else if (slice_eq && idx_q != '0) begin
            idx_d   = idx_q - IW'(1);
            state_d = ST_GAP;
          end else begin
            // Unequal bit, or the LSB matched: the slice answer is final.
            res_d   = slice_res;
            state_d = ST_DONE;
          end
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          res_d   = '0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      ST_GAP: begin
        cnt_d   = '0;
        state_d = ST_REQ;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments only.
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

  assign busy         = (state_q == ST_REQ) || (state_q == ST_GAP);
  assign done         = (state_q == ST_DONE);
  assign slice_req    = (state_q == ST_REQ);
  assign slice_a      = slice_req & a_q[idx_q];
  assign slice_b      = slice_req & b_q[idx_q];
  assign less_than    = res_q.lt;
  assign equal_to     = res_q.eq;
  assign greater_than = res_q.gt;
  assign error        = err_q;

endmodule

// File: tb/tb_compare_sequencer.sv
// Scoreboard bench for compare_sequencer with a behavioural bit-slice responder
// (ack delay, stall and corrupt-result modes).
module tb_compare_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] a, b;
  logic       busy, done, less_than, equal_to, greater_than, error;
  logic       slice_req, slice_a, slice_b;
  logic       slice_ack = 1'b0, slice_lt = 1'b0, slice_eq = 1'b0, slice_gt = 1'b0;

  always #5 clk = ~clk;

  compare_sequencer #(.WIDTH(8), .TIMEOUT(15)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .a            (a),
    .b            (b),
    .busy         (busy),
    .done         (done),
    .less_than    (less_than),
    .equal_to     (equal_to),
    .greater_than (greater_than),
    .error        (error),
    .slice_req    (slice_req),
    .slice_a      (slice_a),
    .slice_b      (slice_b),
    .slice_ack    (slice_ack),
    .slice_lt     (slice_lt),
    .slice_eq     (slice_eq),
    .slice_gt     (slice_gt)
  );

  typedef struct {
    logic [2:0] res;     // {lt, eq, gt}
    logic       err;
    int         nreq;    // slice requests issued
    int         reqcyc;  // cycles with slice_req high
    int         lat;     // done sampled at accept edge + lat
    int         t0;      // index of the accepting edge
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural bit-slice responder, updated away from the active edge.
  typedef enum {M_NORMAL, M_STALL, M_CORRUPT} mode_e;
  mode_e      mode      = M_NORMAL;
  int         ack_delay = 0;
  logic [2:0] bad_res   = 3'b000;
  int         hold      = 0;

  always @(negedge clk) begin : cmp_slice_model
    slice_ack = 1'b0;
    {slice_lt, slice_eq, slice_gt} = 3'b000;
    if (slice_req) begin
      if (mode != M_STALL && hold == ack_delay) begin
        slice_ack = 1'b1;
        if (mode == M_CORRUPT)
          {slice_lt, slice_eq, slice_gt} = bad_res;
        else
          {slice_lt, slice_eq, slice_gt} = {~slice_a & slice_b, slice_a == slice_b, slice_a & ~slice_b};
      end
      hold++;
    end else begin
      hold = 0;
    end
  end

  // Monitor: tracks request activity and scores every done pulse.
  int   m_nreq = 0;
  int   m_reqcyc = 0;
  logic m_prev = 1'b0;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset) begin
      m_nreq = 0; m_reqcyc = 0; m_prev = 1'b0;
    end else begin
      if (slice_req && !m_prev) m_nreq++;
      if (slice_req) m_reqcyc++;
      m_prev = slice_req;
      if (done) begin
        if (sb_q.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          e = sb_q.pop_front();
          check("result", {less_than, equal_to, greater_than}, e.res);
          check("error", error, e.err);
          check("requests", m_nreq, e.nreq);
          check("req_cycles", m_reqcyc, e.reqcyc);
          check("latency", cyc - e.t0 + 1, e.lat);
          check("busy_in_done", busy, 0);
        end
        m_nreq = 0; m_reqcyc = 0;
      end
    end
  end

  // Called at negedge+1; the following posedge accepts the start.
  task automatic issue(input logic [7:0] aa, input logic [7:0] bb, input logic [2:0] res,
                       input logic err, input int nreq, input int reqcyc, input int lat);
    exp_t e;
    a = aa; b = bb; start = 1'b1;
    e = '{res: res, err: err, nreq: nreq, reqcyc: reqcyc, lat: lat, t0: cyc + 1};
    sb_q.push_back(e);
    @(negedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge clk); #1;
      n++;
    end
    if (done !== 1'b1) check("done_timeout", 0, 1);
  endtask

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [2:0] res;
    int         k;
  } vec_t;

  vec_t vecs[5] = '{
    '{8'h5A, 8'h5A, 3'b010, 8},  // equal, all bits examined
    '{8'h80, 8'h7F, 3'b001, 1},  // MSB decides
    '{8'h3C, 8'h3D, 3'b100, 8},  // LSB decides
    '{8'h00, 8'hFF, 3'b100, 1},
    '{8'hA5, 8'hA1, 3'b001, 6}   // bit 2 decides
  };

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : driver
    logic req_seen;
    int   n;

    // Reset with a start held high: reset must win.
    reset = 1'b1; start = 1'b1; a = 8'h01; b = 8'h00;
    repeat (2) @(negedge clk);
    #1;
    check("reset_outputs",
          {busy, done, error, slice_req, slice_a, slice_b, less_than, equal_to, greater_than}, 9'h000);
    start = 1'b0; reset = 1'b0;
    @(negedge clk); #1;

    foreach (vecs[i]) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].res, 1'b0, vecs[i].k, vecs[i].k, 2 * vecs[i].k);
      wait_done(64);
      @(negedge clk); #1;
    end
    check("result_held", {less_than, equal_to, greater_than}, 3'b001);

    // Delayed acks: REQ lasts delay+1 cycles; timeout counter restarts per bit.
    ack_delay = 2;
    issue(8'hC0, 8'h80, 3'b001, 1'b0, 2, 6, 8);
    wait_done(64); @(negedge clk); #1;
    ack_delay = 10;
    issue(8'hC0, 8'h80, 3'b001, 1'b0, 2, 22, 24);
    wait_done(64); @(negedge clk); #1;
    ack_delay = 14;
    issue(8'h80, 8'h00, 3'b001, 1'b0, 1, 15, 16);
    wait_done(64); @(negedge clk); #1;
    ack_delay = 0;

    // Slice never answers: 15 request cycles then an error done.
    mode = M_STALL;
    issue(8'h12, 8'h34, 3'b000, 1'b1, 1, 15, 16);
    wait_done(64); @(negedge clk); #1;

    // Slice answers 000: error, and no retry afterwards.
    mode = M_CORRUPT; bad_res = 3'b000;
    issue(8'h5A, 8'h5A, 3'b000, 1'b1, 1, 1, 2);
    wait_done(64);
    req_seen = 1'b0;
    repeat (4) begin
      @(negedge clk); #1;
      req_seen = req_seen | slice_req;
    end
    check("no_retry_after_error", req_seen, 1'b0);

    bad_res = 3'b011;
    issue(8'h00, 8'h00, 3'b000, 1'b1, 1, 1, 2);
    wait_done(64); @(negedge clk); #1;

    // Error and results clear on the next accepted start.
    mode = M_NORMAL;
    issue(8'h80, 8'h7F, 3'b001, 1'b0, 1, 1, 2);
    check("clear_on_start", {error, less_than, equal_to, greater_than}, 4'h0);
    wait_done(64); @(negedge clk); #1;

    // Reset at the third request aborts without a done pulse.
    a = 8'h5A; b = 8'h5A; start = 1'b1;
    @(negedge clk); #1;
    start = 1'b0;
    n = 0;
    while (m_nreq != 3 && n < 32) begin
      @(negedge clk); #1;
      n++;
    end
    check("third_request_seen", m_nreq, 3);
    reset = 1'b1;
    @(negedge clk); #1;
    check("reset_abort", {slice_req, busy, done}, 3'b000);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    issue(8'h01, 8'h00, 3'b001, 1'b0, 8, 8, 16);
    wait_done(64); @(negedge clk); #1;

    // Starts while busy are ignored; a start in the DONE cycle is accepted.
    issue(8'h3C, 8'h3D, 3'b100, 1'b0, 8, 8, 16);
    repeat (3) begin
      a = 8'hFF; b = 8'h00; start = 1'b1;
      @(negedge clk); #1;
      start = 1'b0;
      @(negedge clk); #1;
    end
    a = 8'h00; b = 8'h00;
    wait_done(64);
    issue(8'h80, 8'h7F, 3'b001, 1'b0, 1, 1, 2);
    check("req_after_done_start", {busy, slice_req}, 2'b11);
    check("clear_on_done_start", {less_than, equal_to, greater_than}, 3'b000);
    wait_done(64);

    repeat (3) @(negedge clk);
    #1;
    check("scoreboard_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
